// File: rtl/bus_mem_port_if.sv
// rtl/bus_mem_port_if.sv - datapath bus and memory handshake signals of bus_mem_port
// mem_rd/mem_wr are the datapath start commands; mem_we is the registered write flag to memory.
interface bus_mem_port_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] bus_in;
   logic              ld_mar;
   logic              ld_mdr;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mar_out;
   logic [DATA_W-1:0] mdr_out;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  bus_in, ld_mar, ld_mdr, mem_rd, mem_wr, mem_rdata, mem_ack,
      output mar_out, mdr_out, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
   );

   modport master (
      output bus_in, ld_mar, ld_mdr, mem_rd, mem_wr, mem_rdata, mem_ack,
      input  mar_out, mdr_out, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
   );
endinterface

// File: rtl/bus_mem_port.sv
// rtl/bus_mem_port.sv - MAR/MDR capture from the datapath bus and req/ack memory transactions
// Optional BUS_MEM_TIMEOUT_EN: abort a transaction after TIMEOUT request cycles without ack.
module bus_mem_port #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst,
   bus_mem_port_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_mem_port: TIMEOUT must be in 2..255");
   end

   logic [1:0]        state;
   logic [DATA_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic              req;
   logic              we;
   logic              done_q;
   logic              err_q;

`ifdef BUS_MEM_TIMEOUT_EN
   localparam logic [DATA_W-1:0] RD_ABORT = DATA_W'(64'hCCCC_CCCC_CCCC_CCCC);
   logic [7:0] timer;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         mar    <= '0;
         mdr    <= '0;
         req    <= 1'b0;
         we     <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef BUS_MEM_TIMEOUT_EN
         timer  <= 8'd0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               // Loads land on the same edge as a request, so the transaction sees the new MAR/MDR
               if (bus.ld_mar) mar <= bus.bus_in;
               if (bus.ld_mdr) mdr <= bus.bus_in;
               if (bus.mem_rd && bus.mem_wr) begin
                  err_q <= 1'b1;
               end else if (bus.mem_rd || bus.mem_wr) begin
                  state <= bus.mem_rd ? S_RD : S_WR;
                  req   <= 1'b1;
                  we    <= bus.mem_wr;
`ifdef BUS_MEM_TIMEOUT_EN
                  timer <= 8'd0;
`endif
               end
            end
            S_RD, S_WR: begin
               // Ack is checked first so an ack on the last allowed cycle still completes
               if (bus.mem_ack) begin
                  if (state == S_RD) mdr <= bus.mem_rdata;
                  state  <= S_IDLE;
                  req    <= 1'b0;
                  we     <= 1'b0;
                  done_q <= 1'b1;
`ifdef BUS_MEM_TIMEOUT_EN
               end else if (timer == 8'(TIMEOUT - 1)) begin
                  if (state == S_RD) mdr <= RD_ABORT;
                  state <= S_IDLE;
                  req   <= 1'b0;
                  we    <= 1'b0;
                  err_q <= 1'b1;
               end else begin
                  timer <= timer + 8'd1;
`endif
               end
            end
            default: begin
               state <= S_IDLE;
               req   <= 1'b0;
               we    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mar_out   = mar;
   assign bus.mdr_out   = mdr;
   assign bus.mem_addr  = mar;
   assign bus.mem_wdata = mdr;
   assign bus.mem_req   = req;
   assign bus.mem_we    = we;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_bus_mem_port.sv
// tb/tb_bus_mem_port.sv - directed and randomized checks of bus_mem_port against a transaction-level model
module tb_bus_mem_port;
   localparam int DW = 16;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_mem_port_if #(.DATA_W(DW)) bif ();

   bus_mem_port #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] mar_m;
   logic [DW-1:0] mdr_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bif.bus_in    = '0;
      bif.ld_mar    = 1'b0;
      bif.ld_mdr    = 1'b0;
      bif.mem_rd    = 1'b0;
      bif.mem_wr    = 1'b0;
      bif.mem_ack   = 1'b0;
      bif.mem_rdata = '0;
   endtask

   // Drive one IDLE-cycle command with optional loads; the model applies loads at that edge.
   task automatic issue(input bit ldmar, input bit ldmdr, input bit rd, input bit wr,
                        input logic [DW-1:0] val);
      bif.bus_in = val;
      bif.ld_mar = ldmar;
      bif.ld_mdr = ldmdr;
      bif.mem_rd = rd;
      bif.mem_wr = wr;
      bif.mem_ack = 1'b0;
      step();
      clear_inputs();
      if (ldmar) mar_m = val;
      if (ldmdr) mdr_m = val;
   endtask

   // Called in the first mem_req cycle; ack is given in request cycle number d (0-based).
   // While busy the datapath side is hammered with random loads/commands that must be ignored.
   task automatic serve(input bit rd, input int d, input logic [DW-1:0] rdata);
      int i = 0;
      bit fin = 1'b0;
      while (!fin) begin
         check("req_high", bif.mem_req, 1'b1);
         check("busy_high", bif.busy, 1'b1);
         check("req_we", bif.mem_we, !rd);
         check("req_addr", bif.mem_addr, mar_m);
         check("req_wdata", bif.mem_wdata, mdr_m);
         check("frozen_mdr", bif.mdr_out, mdr_m);
         check("no_pulse", {bif.done, bif.err}, 2'b00);
         bif.bus_in = 16'hFFFF;
         bif.ld_mar = 1'($urandom);
         bif.ld_mdr = 1'($urandom);
         bif.mem_rd = 1'($urandom);
         bif.mem_wr = 1'($urandom);
         if (i == d) begin
            bif.mem_ack   = 1'b1;
            bif.mem_rdata = rdata;
            step();
            clear_inputs();
            if (rd) mdr_m = rdata;
            check("done_pulse", bif.done, 1'b1);
            check("done_no_err", bif.err, 1'b0);
            check("done_req_low", bif.mem_req, 1'b0);
            check("done_idle", bif.busy, 1'b0);
            check("done_mdr", bif.mdr_out, mdr_m);
            check("done_mar", bif.mar_out, mar_m);
            fin = 1'b1;
`ifdef BUS_MEM_TIMEOUT_EN
         end else if (i == TO - 1) begin
            step();
            clear_inputs();
            if (rd) mdr_m = 16'hCCCC;
            check("abort_err", bif.err, 1'b1);
            check("abort_no_done", bif.done, 1'b0);
            check("abort_req_low", bif.mem_req, 1'b0);
            check("abort_idle", bif.busy, 1'b0);
            check("abort_mdr", bif.mdr_out, mdr_m);
            fin = 1'b1;
`endif
         end else begin
            step();
            clear_inputs();
            i++;
            if (i > 300) begin
               check("serve_bound", 1'b0, 1'b1);
               fin = 1'b1;
            end
         end
      end
   endtask

   initial begin
      int cnt;
      clear_inputs();
      mar_m = '0;
      mdr_m = '0;

      // Reset state, visible without a clock edge
      rst = 1'b1;
      #1;
      check("rst_req", bif.mem_req, 1'b0);
      check("rst_outs", {bif.busy, bif.done, bif.err, bif.mem_we}, 4'b0000);
      check("rst_mar", bif.mar_out, 16'h0000);
      check("rst_mdr", bif.mdr_out, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Load + read with ack in the first request cycle
      issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h3000);
      check("ld_rd_addr", bif.mem_addr, 16'h3000);
      serve(1'b1, 0, 16'hBEEF);
      check("ld_rd_mdr", bif.mdr_out, 16'hBEEF);
      step();
      check("done_one_cycle", bif.done, 1'b0);

      // Write of 1234 to 0010 with three wait cycles
      issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
      issue(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
      serve(1'b0, 3, 16'h5555);
      check("wr_mdr_kept", bif.mdr_out, 16'h1234);
      step();

      // Illegal simultaneous read and write
      issue(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      check("illegal_err", bif.err, 1'b1);
      check("illegal_no_req", bif.mem_req, 1'b0);
      check("illegal_idle", bif.busy, 1'b0);
      step();
      check("illegal_err_once", bif.err, 1'b0);
      check("illegal_still_no_req", bif.mem_req, 1'b0);

      // Back-to-back: new read in the done cycle; mem_req low for just that cycle
      issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      serve(1'b1, 1, 16'hA5A5);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      check("b2b_req_again", bif.mem_req, 1'b1);
      serve(1'b1, 0, 16'h5A5A);
      step();

`ifdef BUS_MEM_TIMEOUT_EN
      // Read with no ack: request held exactly TO cycles, then abort
      issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      cnt = 0;
      while (bif.mem_req && cnt < 100) begin
         cnt++;
         step();
      end
      check("to_req_cycles", cnt, TO);
      check("to_err", bif.err, 1'b1);
      check("to_mdr", bif.mdr_out, 16'hCCCC);
      check("to_idle", bif.busy, 1'b0);
      mdr_m = 16'hCCCC;
      step();
      // Ack on the last allowed cycle completes normally
      issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      serve(1'b1, TO - 1, 16'h7777);
      step();
`else
      // Without a timer the transaction waits as long as it takes
      issue(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      serve(1'b1, 25, 16'h7777);
      cnt = 0;
      step();
`endif

      // Reset in the middle of a read
      issue(1'b1, 1'b1, 1'b1, 1'b0, 16'h4321);
      check("midrd_req", bif.mem_req, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("midrd_req0", bif.mem_req, 1'b0);
      check("midrd_busy0", bif.busy, 1'b0);
      check("midrd_mar0", bif.mar_out, 16'h0000);
      check("midrd_mdr0", bif.mdr_out, 16'h0000);
      mar_m = '0;
      mdr_m = '0;
      @(negedge clk);
      rst = 1'b0;
      step();

      // Randomized transactions against the model
      for (int t = 0; t < 150; t++) begin
         int nidle;
         int cmd;
         int d;
         nidle = $urandom_range(0, 2);
         for (int k = 0; k < nidle; k++) begin
            logic [DW-1:0] v;
            v = 16'($urandom);
            bif.bus_in    = v;
            bif.ld_mar    = 1'($urandom);
            bif.ld_mdr    = 1'($urandom);
            bif.mem_ack   = 1'($urandom);
            bif.mem_rdata = 16'($urandom);
            if (bif.ld_mar) mar_m = v;
            if (bif.ld_mdr) mdr_m = v;
            step();
            clear_inputs();
            check("idle_pulses", {bif.done, bif.err, bif.busy, bif.mem_req}, 4'b0000);
            check("idle_mar", bif.mar_out, mar_m);
            check("idle_mdr", bif.mdr_out, mdr_m);
         end
         cmd = $urandom_range(0, 3);
         issue(1'($urandom), 1'($urandom), (cmd == 1) || (cmd == 3), (cmd == 2) || (cmd == 3),
               16'($urandom));
         check("cmd_mar", bif.mar_out, mar_m);
         check("cmd_mdr", bif.mdr_out, mdr_m);
         if (cmd == 3) begin
            check("rnd_illegal", {bif.err, bif.done, bif.mem_req}, 3'b100);
         end else if (cmd == 0) begin
            check("rnd_none", {bif.err, bif.done, bif.mem_req}, 3'b000);
         end else begin
`ifdef BUS_MEM_TIMEOUT_EN
            d = $urandom_range(0, TO + 3);
`else
            d = $urandom_range(0, 6);
`endif
            serve(cmd == 1, d, 16'($urandom));
         end
         step();
         check("rnd_quiet", {bif.done, bif.err}, 2'b00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
